mux_bist: RTL and testbench
===========================

MUX_BIST -- requirements
Module: mux_bist

Interface
REQ-001 The block SHALL be a synthesizable built-in self-test engine that exhaustively drives and checks a 2:1 multiplexer DUT (z = c ? b : a) over one clock domain.
REQ-002 Parameter W, default 1, meaning the data width of the mux under test; legal values are 1 to 4.
REQ-003 Parameter SETTLE, default 2, meaning the number of cycles a vector is held before checking; the minimum legal value is 1.
REQ-004 Derived value NVEC = 2^(2W+1), the number of vectors; derived value CW = 2W+2, the counter width.
REQ-005 clk  input  1  the single clock; all state changes on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  level-sampled request to begin a run.
REQ-008 abort  input  1  terminates a run in progress.
REQ-009 dut_a  output  W  mux data input 0 to the DUT.
REQ-010 dut_b  output  W  mux data input 1 to the DUT.
REQ-011 dut_c  output  1  mux select to the DUT.
REQ-012 dut_z  input  W  DUT response.
REQ-013 busy  output  1  high while a run is active.
REQ-014 done  output  1  high while completed results are held.
REQ-015 pass_cnt  output  CW  number of vectors that matched.
REQ-016 fail_cnt  output  CW  number of vectors that mismatched.
REQ-017 first_fail  output  2W+1  vector index of the earliest mismatch.

Function
REQ-018 The vector index v SHALL be 2W+1 bits wide and map as dut_c = v[0], dut_b = v[W:1], and dut_a = v[2W:W+1], so that select is the innermost loop and a is the outermost.
REQ-019 The FSM SHALL have four states: IDLE, APPLY, CHECK and DONE.
REQ-020 In IDLE or DONE with start=1, at the next edge the block SHALL:
  - enter APPLY with v=0;
  - clear pass_cnt, fail_cnt and first_fail;
  - clear done;
  - set busy=1.
REQ-021 The dut_a, dut_b and dut_c outputs SHALL be registered and SHALL reflect v whenever busy=1.
REQ-022 APPLY SHALL last exactly SETTLE cycles, counted by an internal settle counter, and then go to CHECK.
REQ-023 CHECK SHALL last one cycle; at its closing edge the block SHALL sample dut_z and compare it with the expected value (dut_c ? dut_b : dut_a) using a full W-bit equality.
REQ-024 On a match, pass_cnt SHALL increment by 1; on a mismatch, fail_cnt SHALL increment by 1.
REQ-025 On a mismatch, first_fail SHALL load v if and only if fail_cnt was 0 before that edge.
REQ-026 At the same CHECK edge, if v is less than NVEC-1, then v SHALL increment and the state SHALL return to APPLY with the settle counter reloaded.
REQ-027 At the same CHECK edge, if v equals NVEC-1, the state SHALL go to DONE with busy=0 and done=1.
REQ-028 Latency: if start is accepted at edge k, done SHALL first read 1 after edge k + NVEC*(SETTLE+1).
REQ-029 In DONE, the counters and first_fail SHALL hold their values and dut_* SHALL return to 0.
REQ-030 The start input SHALL be ignored while busy=1.
REQ-031 When abort=1 while busy=1, at the next edge the block SHALL go to IDLE with busy=0, done=0 and dut_*=0, and the counters SHALL retain their partial values.
REQ-032 When abort=1 outside a run, it SHALL have no effect.
REQ-033 When start=1 and abort=1 together in IDLE or DONE, abort SHALL win and no run SHALL start.
REQ-034 The counters SHALL NOT wrap: at done, pass_cnt + fail_cnt SHALL equal NVEC.

Reset
REQ-035 When reset=1, at the next edge the block SHALL enter IDLE with:
  - busy=0 and done=0;
  - dut_a=0, dut_b=0 and dut_c=0;
  - pass_cnt=0, fail_cnt=0 and first_fail=0;
  - v=0 and the settle counter at 0.
REQ-036 reset SHALL take priority over start, abort and every FSM transition, including in the middle of a run.

Verification (W=1, SETTLE=2, so NVEC=8 and done follows 24 edges after start)
REQ-037 Correct combinational mux DUT, start pulse -> busy for 24 cycles, then done=1, pass_cnt=8, fail_cnt=0, first_fail=0.
REQ-038 dut_z stuck at 0 -> pass_cnt=4, fail_cnt=4 (vectors 3, 4, 6, 7), first_fail=3.
REQ-039 DUT with swapped select (z = c ? a : b) -> pass_cnt=4, fail_cnt=4 (vectors 2, 3, 4, 5), first_fail=2.
REQ-040 Correct DUT, abort asserted during the CHECK of vector 4 -> IDLE, done=0, and pass_cnt=4 if abort is sampled before that CHECK edge.
REQ-041 Reset asserted mid-run at vector 5, then start with start held high throughout the run -> all outputs are 0 after reset, and the new run yields pass_cnt=8 with start ignored while busy.
REQ-042 Start issued while in DONE after a failing run -> the counters clear on the accepting edge, and a correct DUT then yields pass_cnt=8 and fail_cnt=0.

Source files
------------

// File: rtl/mux_bist_if.sv
// Signal bundle between the mux BIST engine and its environment:
// run control (start/abort), the mux stimulus/response pair, and result reporting.
interface mux_bist_if #(
    parameter int W = 1
);
    localparam int VW = 2 * W + 1;   // vector index width
    localparam int CW = 2 * W + 2;   // result counter width

    logic          start;
    logic          abort;
    logic [W-1:0]  dut_a;
    logic [W-1:0]  dut_b;
    logic          dut_c;
    logic [W-1:0]  dut_z;
    logic          busy;
    logic          done;
    logic [CW-1:0] pass_cnt;
    logic [CW-1:0] fail_cnt;
    logic [VW-1:0] first_fail;

    // BIST engine side
    modport master (
        input  start, abort, dut_z,
        output dut_a, dut_b, dut_c, busy, done, pass_cnt, fail_cnt, first_fail
    );

    // Environment side: requester plus the mux under test
    modport slave (
        output start, abort, dut_z,
        input  dut_a, dut_b, dut_c, busy, done, pass_cnt, fail_cnt, first_fail
    );
endinterface

// File: rtl/mux_bist.sv
// Built-in self-test engine for a W-bit 2:1 mux (z = c ? b : a).
// Walks every {a, b, c} combination, holds each for SETTLE cycles, checks the
// response for one cycle and accumulates pass/fail counts plus the first failing index.
module mux_bist #(
    parameter int W      = 1,
    parameter int SETTLE = 2
) (
    input  logic      clk,
    input  logic      reset,
    mux_bist_if.master bus
);
    localparam int VW = 2 * W + 1;
    localparam int CW = 2 * W + 2;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE - 1);
    localparam logic [SW-1:0] SETTLE_ONE  = SW'(1);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
    localparam logic [VW-1:0] VEC_ONE     = VW'(1);

    typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

    state_t        state,    state_nxt;
    logic [VW-1:0] v,        v_nxt;
    logic [SW-1:0] settle,   settle_nxt;
    logic          busy_q,   busy_nxt;
    logic          done_q,   done_nxt;
    logic [W-1:0]  a_q,      a_nxt;
    logic [W-1:0]  b_q,      b_nxt;
    logic          c_q,      c_nxt;
    logic [CW-1:0] pass_q,   pass_nxt;
    logic [CW-1:0] fail_q,   fail_nxt;
    logic [VW-1:0] ffail_q,  ffail_nxt;

    logic [W-1:0]  expected;
    logic          match;

    // The stimulus registers already hold the current vector, so the golden
    // value comes straight from them.
    assign expected = c_q ? b_q : a_q;
    assign match    = (bus.dut_z == expected);

    // Next-state and next-output logic for the walk over all vectors.
    always_comb begin
        // NOTE: every target gets a hold/default value first so no path leaves it unassigned (no latches).
        state_nxt  = state;
        v_nxt      = v;
        settle_nxt = settle;
        busy_nxt   = busy_q;
        done_nxt   = done_q;
        pass_nxt   = pass_q;
        fail_nxt   = fail_q;
        ffail_nxt  = ffail_q;

        case (state)
            IDLE, DONE: begin
                // abort beats start; alone it changes nothing outside a run
                if (bus.start && !bus.abort) begin
                    state_nxt  = APPLY;
                    v_nxt      = '0;
                    settle_nxt = SETTLE_LOAD;
                    busy_nxt   = 1'b1;
                    done_nxt   = 1'b0;
                    pass_nxt   = '0;
                    fail_nxt   = '0;
                    ffail_nxt  = '0;
                end
            end
            APPLY: begin
                if (bus.abort) begin
                    state_nxt = IDLE;
                    v_nxt     = '0;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b0;
                end else if (settle == '0) begin
                    state_nxt = CHECK;
                end else begin
                    settle_nxt = settle - SETTLE_ONE;
                end
            end
            CHECK: begin
                // an abort here discards this vector's result
                if (bus.abort) begin
                    state_nxt = IDLE;
                    v_nxt     = '0;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b0;
                end else begin
                    if (match) begin
                        pass_nxt = pass_q + CNT_ONE;
                    end else begin
                        fail_nxt = fail_q + CNT_ONE;
                        if (fail_q == '0) begin
                            ffail_nxt = v;
                        end
                    end
                    if (&v) begin
                        state_nxt = DONE;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt  = APPLY;
                        v_nxt      = v + VEC_ONE;
                        settle_nxt = SETTLE_LOAD;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Stimulus follows the vector index during a run and parks at zero otherwise.
        {a_nxt, b_nxt, c_nxt} = busy_nxt ? v_nxt : '0;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state   <= IDLE;
            v       <= '0;
            settle  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            pass_q  <= '0;
            fail_q  <= '0;
            ffail_q <= '0;
        end else begin
            state   <= state_nxt;
            v       <= v_nxt;
            settle  <= settle_nxt;
            busy_q  <= busy_nxt;
            done_q  <= done_nxt;
            a_q     <= a_nxt;
            b_q     <= b_nxt;
            c_q     <= c_nxt;
            pass_q  <= pass_nxt;
            fail_q  <= fail_nxt;
            ffail_q <= ffail_nxt;
        end
    end

    assign bus.dut_a      = a_q;
    assign bus.dut_b      = b_q;
    assign bus.dut_c      = c_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass_cnt   = pass_q;
    assign bus.fail_cnt   = fail_q;
    assign bus.first_fail = ffail_q;
endmodule

// File: tb/tb_mux_bist.sv
// Scoreboarded bench for mux_bist with a switchable mux model
// (good, output stuck at 0, select swapped).
module tb_mux_bist;
    localparam int W      = 1;
    localparam int SETTLE = 2;
    localparam int NVEC   = 1 << (2 * W + 1);
    localparam int PERIOD = SETTLE + 1;

    logic clk = 1'b0;
    logic reset;
    int   mode;   // 0 good mux, 1 stuck-at-0, 2 swapped select

    always #5 clk = ~clk;

    mux_bist_if #(.W(W)) bus ();

    mux_bist #(.W(W), .SETTLE(SETTLE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Mux under test
    assign bus.dut_z = (mode == 1) ? '0 :
                       (mode == 2) ? (bus.dut_c ? bus.dut_a : bus.dut_b) :
                                     (bus.dut_c ? bus.dut_b : bus.dut_a);

    typedef struct {
        int done;
        int pass_cnt;
        int fail_cnt;
        int first_fail;
        int cycles;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input longint actual, input longint expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    endtask

    // Outcome of a run over vectors 0..limit-1 against the given mux fault.
    function automatic exp_t model(input int fault, input int limit, input int cycles);
        exp_t e;
        int   mask = (1 << W) - 1;
        e.done       = (limit == NVEC) ? 1 : 0;
        e.pass_cnt   = 0;
        e.fail_cnt   = 0;
        e.first_fail = 0;
        e.cycles     = cycles;
        for (int vi = 0; vi < limit; vi++) begin
            int c    = vi & 1;
            int b    = (vi >> 1) & mask;
            int a    = (vi >> (W + 1)) & mask;
            int want = c ? b : a;
            int got  = (fault == 1) ? 0 : (fault == 2) ? (c ? a : b) : want;
            if (got == want) e.pass_cnt++;
            else begin
                if (e.fail_cnt == 0) e.first_fail = vi;
                e.fail_cnt++;
            end
        end
        return e;
    endfunction

    // Monitor: follows each run, checks the stimulus sequence and scores the end of run.
    initial begin : monitor
        bit   busy_prev = 1'b0;
        int   busy_cycles = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.busy === 1'b1) begin
                if (!busy_prev) begin
                    busy_cycles = 0;
                    check("start_clear_pass", bus.pass_cnt, 0);
                    check("start_clear_fail", bus.fail_cnt, 0);
                    check("start_clear_first", bus.first_fail, 0);
                    check("start_clear_done", bus.done, 0);
                end
                check("vector", {bus.dut_a, bus.dut_b, bus.dut_c}, busy_cycles / PERIOD);
                busy_cycles++;
            end else if (busy_prev) begin
                if (sb_q.size() == 0) begin
                    check("sb_underflow", sb_q.size(), 1);
                end else begin
                    e = sb_q.pop_front();
                    check("end_done", bus.done, e.done);
                    check("end_pass_cnt", bus.pass_cnt, e.pass_cnt);
                    check("end_fail_cnt", bus.fail_cnt, e.fail_cnt);
                    check("end_first_fail", bus.first_fail, e.first_fail);
                    check("end_busy_cycles", busy_cycles, e.cycles);
                    check("end_dut_zero", {bus.dut_a, bus.dut_b, bus.dut_c}, 0);
                end
            end
            busy_prev = (bus.busy === 1'b1);
        end
    end

    // One run: abort_at < 0 runs to completion, otherwise abort lands on that vector's CHECK.
    task automatic do_run(input int fault, input int abort_at, input bit hold);
        int limit = (abort_at < 0) ? NVEC : abort_at;
        int cyc   = (abort_at < 0) ? NVEC * PERIOD : PERIOD * abort_at + PERIOD;
        bit got   = 1'b0;
        mode = fault;
        sb_q.push_back(model(fault, limit, cyc));
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        if (!hold) bus.start = 1'b0;
        if (abort_at >= 0) begin
            repeat (PERIOD * abort_at + SETTLE) @(negedge clk);
            bus.abort = 1'b1;
            @(negedge clk);
            bus.abort = 1'b0;
        end else begin
            for (int i = 0; i < NVEC * PERIOD + 20 && !got; i++) begin
                @(negedge clk);
                got = (bus.done === 1'b1);
            end
            check("done_seen", got, 1);
        end
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stimulus
        bus.start = 1'b0;
        bus.abort = 1'b0;
        mode      = 0;
        reset     = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_dut", {bus.dut_a, bus.dut_b, bus.dut_c}, 0);
        check("reset_pass", bus.pass_cnt, 0);
        check("reset_fail", bus.fail_cnt, 0);
        check("reset_first", bus.first_fail, 0);
        reset = 1'b0;

        // start and abort together in IDLE: nothing starts
        @(negedge clk);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("idle_start_abort_busy", bus.busy, 0);

        do_run(0, -1, 1'b0);

        // abort alone in DONE changes nothing
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("done_abort_done", bus.done, 1);
        check("done_abort_pass", bus.pass_cnt, NVEC);

        // start and abort together in DONE: no run, results held
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        @(negedge clk);
        check("done_start_abort_busy", bus.busy, 0);
        check("done_start_abort_done", bus.done, 1);
        check("done_start_abort_pass", bus.pass_cnt, NVEC);

        do_run(1, -1, 1'b0);   // stuck at 0
        do_run(2, -1, 1'b0);   // swapped select
        do_run(0, -1, 1'b0);   // restart from DONE after a failing run
        do_run(0, 4, 1'b0);    // abort on CHECK of vector 4

        // reset in the middle of vector 5
        mode = 0;
        sb_q.push_back(model(0, 0, PERIOD * 5 + 1));
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (PERIOD * 5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_busy", bus.busy, 0);
        check("midrst_done", bus.done, 0);
        check("midrst_dut", {bus.dut_a, bus.dut_b, bus.dut_c}, 0);
        check("midrst_pass", bus.pass_cnt, 0);
        check("midrst_fail", bus.fail_cnt, 0);
        check("midrst_first", bus.first_fail, 0);

        do_run(0, -1, 1'b1);   // start held high for the whole run

        repeat (8) begin
            int f  = $urandom_range(0, 2);
            int ab = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, NVEC - 1)) : -1;
            do_run(f, ab, 1'b0);
        end

        repeat (5) @(negedge clk);
        check("sb_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
